pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
Parametrised fetch-address unit that replaces the old combinational next-PC selector.
- Owns the PC register, the EPC register and the exception-level (EXL) flag.
- Resolves six branch conditions internally from register operands, with no external zero flag.
- Arbitrates stall, synchronous exception, external interrupt and ERET.
- Sits between the controller/regfile and instruction memory; drives the fetch address every cycle.

Parameters:
- WIDTH, 32, address/data width; must be >= 28.
- RESET_PC, 32'h0000_3000, PC loaded on reset.
- EXC_VECTOR, 32'h0000_4180, exception/interrupt entry address.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold PC/EPC/EXL this cycle
- pc_src  input  3  000 seq, 001 branch, 010 j/jal, 011 jr/jalr, 100 sync exception, 101 eret; 11x reserved (treated as seq)
- br_cond  input  3  000 beq, 001 bne, 010 blez, 011 bgtz, 100 bltz, 101 bgez; 11x never taken
- rs_val  input  WIDTH  rs operand, also jr target
- rt_val  input  WIDTH  rt operand
- instr  input  32  current instruction (imm16 / idx26)
- int_req  input  1  level interrupt request
- int_en  input  1  global interrupt enable
- pc  output  WIDTH  current fetch address
- pc_plus4  output  WIDTH  pc+4, for jal link
- epc  output  WIDTH  saved return address
- exl  output  1  exception level; 1 = inside handler
- exc_taken  output  1  one-cycle pulse, registered, on the cycle after vector entry
- br_taken  output  1  combinational: branch condition true and pc_src==001

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, epc=0, exl=0, exc_taken=0. All registers leave reset on the first rising edge with rst_n=1.
- Combinational targets:
  - seq = pc+4
  - br = pc+4 + (sext(imm16)<<2) when the condition holds, else pc+4
  - jmp = {pc[WIDTH-1:28], idx26, 2'b00}
  - jr = rs_val
- Branch compare: beq/bne use equality; the others use signed rs_val against zero. This is delay-slot-free: taken branches are relative to pc+4; arithmetic is modulo 2^WIDTH.
- Interrupt acceptance: irq_go = int_req & int_en & ~exl & ~stall.
- Per-edge priority:
  1. stall=1: all registers hold, and exc_taken <= 0. An int_req during a stall is not lost if it is still high afterwards; it is level-sensitive and not latched.
  2. pc_src==100 (sync exception): epc <= pc (faulting instruction), pc <= EXC_VECTOR, exl <= 1, exc_taken <= 1. This happens regardless of exl; a nested exception overwrites epc.
  3. irq_go=1 while pc_src!=100: epc <= the normal next PC that would have been loaded (resume address), pc <= EXC_VECTOR, exl <= 1, exc_taken <= 1. If pc_src==101 in the same cycle, the ERET is squashed: epc <= epc, exl stays 1.
  4. pc_src==101 (eret): pc <= epc, exl <= 0.
  5. Otherwise: pc <= selected target, exc_taken <= 0.
- pc_plus4 is always pc+4, combinational.
- Latency: selection takes effect on the next edge; a one-cycle stall delays it by exactly one cycle.

Optional Feature:
- Macro: PC_UNIT_ALIGN_CHECK_EN.
- With the macro defined: if the chosen non-exception target has bits [1:0] != 0 (only possible via jr), treat the cycle as a sync exception with epc <= pc. An extra output port, addr_err (1 bit), pulses high for one cycle together with exc_taken.
- Without the macro: no check, the addr_err port is absent, and misaligned jr targets load verbatim.

Decomposition:
- Shared package mips_pkg holds:
  - PCSRC_* (3-bit) and BR_* (3-bit) encodings
  - default RESET_PC and EXC_VECTOR constants
- One natural sub-module, br_cmp: purely combinational condition evaluator (rs_val, rt_val, br_cond -> taken).

Test Plan:
- Reset then 3 seq cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; epc=0, exl=0.
- pc=0x3010, beq with rs=rt=5, imm=0xFFFE -> pc=0x300C. Then bgtz with rs=0xFFFFFFFF -> not taken, pc=0x3010.
- pc=0x3020, j idx26=0x0000C40 -> pc=0x3100. Then jr rs=0x3200 with stall=1 for 2 cycles -> pc holds 0x3100, then becomes 0x3200.
- pc=0x3040, int_req=1, int_en=1 -> pc=0x4180, epc=0x3044, exl=1, exc_taken pulses once. While exl=1, int_req stays ignored. eret -> pc=0x3044, exl=0.
- pc=0x3050 with pc_src=100 and int_req=1 in the same cycle -> epc=0x3050 (sync wins), pc=0x4180.
- rst_n dropped asynchronously mid-handler (exl=1) -> pc=0x3000, exl=0, epc=0 without waiting for a clock edge.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Encodings and default addresses shared by the fetch-address
//                unit, its branch comparator and its bus interface.
//                  PCSRC_* : next-PC source select (3 bit)
//                  BR_*    : branch condition select (3 bit)
//                  DEF_RESET_PC / DEF_EXC_VECTOR : default address constants
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

   // Next-PC source select. Codes 3'b110/3'b111 are reserved and fall back
   // to sequential fetch.
   typedef enum logic [2:0] {
      PCSRC_SEQ  = 3'b000,
      PCSRC_BR   = 3'b001,
      PCSRC_JMP  = 3'b010,
      PCSRC_JR   = 3'b011,
      PCSRC_EXC  = 3'b100,
      PCSRC_ERET = 3'b101
   } pc_src_e;

   // Branch condition select. Codes 3'b110/3'b111 are never taken.
   typedef enum logic [2:0] {
      BR_EQ  = 3'b000,
      BR_NE  = 3'b001,
      BR_LEZ = 3'b010,
      BR_GTZ = 3'b011,
      BR_LTZ = 3'b100,
      BR_GEZ = 3'b101
   } br_cond_e;

   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pc_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit_if
//  Description : Control/fetch bus between the controller + register file and
//                the fetch-address unit.
//                Controller -> unit : stall, pc_src[2:0], br_cond[2:0],
//                                     rs_val, rt_val, instr[31:0],
//                                     int_req, int_en
//                Unit -> controller : pc, pc_plus4, epc, exl, exc_taken,
//                                     br_taken (+ addr_err when the macro
//                                     PC_UNIT_ALIGN_CHECK_EN is defined)
//                Modports: master (controller side), slave (pc_unit side).
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_unit_if #(
   parameter int WIDTH = 32
);
   logic             stall;
   logic [2:0]       pc_src;
   logic [2:0]       br_cond;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic [31:0]      instr;
   logic             int_req;
   logic             int_en;

   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus4;
   logic [WIDTH-1:0] epc;
   logic             exl;
   logic             exc_taken;
   logic             br_taken;
`ifdef PC_UNIT_ALIGN_CHECK_EN
   logic             addr_err;
`endif

   modport master (
      output stall, pc_src, br_cond, rs_val, rt_val, instr, int_req, int_en,
`ifdef PC_UNIT_ALIGN_CHECK_EN
      input  addr_err,
`endif
      input  pc, pc_plus4, epc, exl, exc_taken, br_taken
   );

   modport slave (
      input  stall, pc_src, br_cond, rs_val, rt_val, instr, int_req, int_en,
`ifdef PC_UNIT_ALIGN_CHECK_EN
      output addr_err,
`endif
      output pc, pc_plus4, epc, exl, exc_taken, br_taken
   );

endinterface : pc_unit_if
`default_nettype wire

// File: rtl/pc_unit_br_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : br_cmp
//  Description : Purely combinational branch-condition evaluator.
//                  rs_val, rt_val [WIDTH] : register operands
//                  br_cond [3]            : condition select (BR_*)
//                  taken                  : condition holds
//                beq/bne compare rs against rt; the remaining conditions test
//                rs as a signed value against zero. Reserved codes never take.
//  Revision    : 1.0  initial release
// ============================================================================
module br_cmp
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  wire logic [WIDTH-1:0] rs_val,
   input  wire logic [WIDTH-1:0] rt_val,
   input  wire logic [2:0]       br_cond,
   output logic                  taken
);

   logic w_eq;
   logic w_zero;
   logic w_neg;

   assign w_eq   = (rs_val == rt_val);
   assign w_zero = (rs_val == '0);
   assign w_neg  = rs_val[WIDTH-1];

   always_comb begin
      taken = 1'b0;
      case (br_cond)
         BR_EQ  : taken = w_eq;
         BR_NE  : taken = ~w_eq;
         BR_LEZ : taken = w_neg | w_zero;
         BR_GTZ : taken = ~w_neg & ~w_zero;
         BR_LTZ : taken = w_neg;
         BR_GEZ : taken = ~w_neg;
         default: taken = 1'b0;
      endcase
   end

endmodule : br_cmp
`default_nettype wire

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_unit
//  Description : Fetch-address unit. Owns the PC, EPC and exception-level
//                flag; resolves branches internally and arbitrates stall,
//                synchronous exception, external interrupt and ERET.
//  Ports       : clk    - clock, rising edge
//                rst_n  - asynchronous active-low reset
//                bus    - pc_unit_if.slave (control inputs, fetch outputs)
//  Parameters  : WIDTH (>= 28), RESET_PC, EXC_VECTOR
//  Options     : PC_UNIT_ALIGN_CHECK_EN - misaligned non-exception targets
//                raise a synchronous exception and pulse bus.addr_err.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_unit
   import mips_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEF_RESET_PC),
   parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
   input  wire logic clk,
   input  wire logic rst_n,
   pc_unit_if.slave  bus
);

   localparam logic [WIDTH-1:0] c_four = WIDTH'(4);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_epc;
   logic             r_exl;
   logic             r_exc_taken;

   logic [WIDTH-1:0] w_pc_nxt;
   logic [WIDTH-1:0] w_epc_nxt;
   logic             w_exl_nxt;
   logic             w_exc_nxt;

   // ------------------------------------------------------------------------
   // Candidate targets
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] w_pc_plus4;
   logic [WIDTH-1:0] w_br_off;
   logic [WIDTH-1:0] w_br_tgt;
   logic [WIDTH-1:0] w_jmp_tgt;
   logic [WIDTH-1:0] w_next;
   logic             w_cond;
   logic             w_br_taken;
   logic             w_sync;
   logic             w_irq_go;
   logic             w_unused;

   assign w_pc_plus4 = r_pc + c_four;

   // sext(imm16) << 2; WIDTH >= 28 guarantees the replication count is > 0
   assign w_br_off = {{(WIDTH-18){bus.instr[15]}}, bus.instr[15:0], 2'b00};

   br_cmp #(
      .WIDTH   (WIDTH)
   ) u_br_cmp (
      .rs_val  (bus.rs_val),
      .rt_val  (bus.rt_val),
      .br_cond (bus.br_cond),
      .taken   (w_cond)
   );

   assign w_br_taken = w_cond & (bus.pc_src == PCSRC_BR);
   assign w_br_tgt   = w_br_taken ? (w_pc_plus4 + w_br_off) : w_pc_plus4;

   // Region jump keeps the PC bits above the 256 MB segment, if any exist.
   generate
      if (WIDTH > 28) begin : g_jmp_region
         assign w_jmp_tgt = {r_pc[WIDTH-1:28], bus.instr[25:0], 2'b00};
      end else begin : g_jmp_flat
         assign w_jmp_tgt = {bus.instr[25:0], 2'b00};
      end
   endgenerate

   // Opcode field is decoded by the controller, not here.
   assign w_unused = &{1'b0, bus.instr[31:26]};

   // Normal (non-exception) next PC. ERET's destination is included so an
   // interrupt arriving alongside it has a well-defined resume address, even
   // though that case keeps the old EPC.
   always_comb begin
      w_next = w_pc_plus4;
      case (bus.pc_src)
         PCSRC_BR  : w_next = w_br_tgt;
         PCSRC_JMP : w_next = w_jmp_tgt;
         PCSRC_JR  : w_next = bus.rs_val;
         PCSRC_ERET: w_next = r_epc;
         default   : w_next = w_pc_plus4;
      endcase
   end

`ifdef PC_UNIT_ALIGN_CHECK_EN
   logic w_misalign;
   logic r_addr_err;

   // Only a register-indirect jump can produce a misaligned target in
   // practice, but every normal path is checked.
   assign w_misalign = (bus.pc_src != PCSRC_EXC) && (w_next[1:0] != 2'b00);
   assign w_sync     = (bus.pc_src == PCSRC_EXC) | w_misalign;
`else
   assign w_sync     = (bus.pc_src == PCSRC_EXC);
`endif

   // Level-sensitive: a request seen during a stall is simply re-sampled on
   // the next unstalled cycle.
   assign w_irq_go = bus.int_req & bus.int_en & ~r_exl & ~bus.stall;

   // ------------------------------------------------------------------------
   // Next-state arbitration: stall > sync exception > interrupt > eret > normal
   // ------------------------------------------------------------------------
   always_comb begin
      w_pc_nxt  = r_pc;
      w_epc_nxt = r_epc;
      w_exl_nxt = r_exl;
      w_exc_nxt = 1'b0;
      if (!bus.stall) begin
         if (w_sync) begin
            w_epc_nxt = r_pc;
            w_pc_nxt  = EXC_VECTOR;
            w_exl_nxt = 1'b1;
            w_exc_nxt = 1'b1;
         end else if (w_irq_go) begin
            // A simultaneous ERET is squashed: EPC keeps its value.
            w_epc_nxt = (bus.pc_src == PCSRC_ERET) ? r_epc : w_next;
            w_pc_nxt  = EXC_VECTOR;
            w_exl_nxt = 1'b1;
            w_exc_nxt = 1'b1;
         end else if (bus.pc_src == PCSRC_ERET) begin
            w_pc_nxt  = r_epc;
            w_exl_nxt = 1'b0;
         end else begin
            w_pc_nxt  = w_next;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc        <= RESET_PC;
         r_epc       <= '0;
         r_exl       <= 1'b0;
         r_exc_taken <= 1'b0;
      end else begin
         r_pc        <= w_pc_nxt;
         r_epc       <= w_epc_nxt;
         r_exl       <= w_exl_nxt;
         r_exc_taken <= w_exc_nxt;
      end
   end

`ifdef PC_UNIT_ALIGN_CHECK_EN
   // Flags the exception entry caused by the alignment check; pulses in the
   // same cycle as exc_taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr_err <= 1'b0;
      end else begin
         r_addr_err <= ~bus.stall & w_misalign;
      end
   end

   assign bus.addr_err = r_addr_err;
`endif

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.pc        = r_pc;
   assign bus.pc_plus4  = w_pc_plus4;
   assign bus.epc       = r_epc;
   assign bus.exl       = r_exl;
   assign bus.exc_taken = r_exc_taken;
   assign bus.br_taken  = w_br_taken;

endmodule : pc_unit
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_unit
//  Description : Directed self-checking bench for pc_unit. Walks sequential
//                fetch, branches, jumps, stalls, interrupt entry/return,
//                exception priority and asynchronous reset, then a table of
//                branch conditions. Honours PC_UNIT_ALIGN_CHECK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_unit;
   import mips_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   pc_unit_if #(.WIDTH(32)) bus ();

   pc_unit #(
      .WIDTH      (32),
      .RESET_PC   (32'h0000_3000),
      .EXC_VECTOR (32'h0000_4180)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] src, input logic [2:0] cond,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] ins);
      bus.pc_src  = src;
      bus.br_cond = cond;
      bus.rs_val  = rs;
      bus.rt_val  = rt;
      bus.instr   = ins;
   endtask

   // Branch-condition vectors: cond, rs, rt, expected taken
   typedef struct {
      logic [2:0]  cond;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        exp;
   } br_vec_t;

   br_vec_t br_tab[10];

   initial begin
      br_tab[0] = '{3'b001, 32'd5,          32'd6, 1'b1};  // bne differ
      br_tab[1] = '{3'b001, 32'd7,          32'd7, 1'b0};  // bne equal
      br_tab[2] = '{3'b010, 32'd0,          32'd0, 1'b1};  // blez zero
      br_tab[3] = '{3'b010, 32'd1,          32'd0, 1'b0};  // blez positive
      br_tab[4] = '{3'b011, 32'd1,          32'd0, 1'b1};  // bgtz positive
      br_tab[5] = '{3'b100, 32'h8000_0000,  32'd0, 1'b1};  // bltz most negative
      br_tab[6] = '{3'b100, 32'd0,          32'd0, 1'b0};  // bltz zero
      br_tab[7] = '{3'b101, 32'd0,          32'd0, 1'b1};  // bgez zero
      br_tab[8] = '{3'b101, 32'hFFFF_FFFF,  32'd0, 1'b0};  // bgez -1
      br_tab[9] = '{3'b110, 32'd3,          32'd3, 1'b0};  // reserved
   end

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      rst_n       = 1'b0;
      bus.stall   = 1'b0;
      bus.int_req = 1'b0;
      bus.int_en  = 1'b0;
      drive(PCSRC_SEQ, BR_EQ, 32'd0, 32'd0, 32'd0);

      // ---------------- reset state ----------------
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc",        bus.pc,        32'h0000_3000);
      check("rst_epc",       bus.epc,       32'h0);
      check("rst_exl",       {31'd0, bus.exl},       32'h0);
      check("rst_exc_taken", {31'd0, bus.exc_taken}, 32'h0);
      check("rst_pc_plus4",  bus.pc_plus4,  32'h0000_3004);
      rst_n = 1'b1;

      // ---------------- sequential fetch ----------------
      tick(); check("seq1", bus.pc, 32'h0000_3004);
      tick(); check("seq2", bus.pc, 32'h0000_3008);
      tick(); check("seq3", bus.pc, 32'h0000_300C);
      check("seq_epc", bus.epc, 32'h0);
      check("seq_exl", {31'd0, bus.exl}, 32'h0);
      tick(); check("seq4", bus.pc, 32'h0000_3010);

      // ---------------- beq taken, backward ----------------
      drive(PCSRC_BR, BR_EQ, 32'd5, 32'd5, 32'h1085_FFFE);
      #1 check("beq_br_taken", {31'd0, bus.br_taken}, 32'h1);
      tick(); check("beq_pc", bus.pc, 32'h0000_300C);

      // ---------------- bgtz on -1: not taken ----------------
      drive(PCSRC_BR, BR_GTZ, 32'hFFFF_FFFF, 32'd0, 32'h1C20_0040);
      #1 check("bgtz_br_taken", {31'd0, bus.br_taken}, 32'h0);
      tick(); check("bgtz_pc", bus.pc, 32'h0000_3010);

      // ---------------- walk to 0x3020, then j ----------------
      drive(PCSRC_SEQ, BR_EQ, 32'd0, 32'd0, 32'd0);
      repeat (4) tick();
      check("pre_j_pc", bus.pc, 32'h0000_3020);
      drive(PCSRC_JMP, BR_EQ, 32'd0, 32'd0, 32'h0800_0C40);
      tick(); check("j_pc", bus.pc, 32'h0000_3100);

      // ---------------- jr held by a two-cycle stall ----------------
      drive(PCSRC_JR, BR_EQ, 32'h0000_3200, 32'd0, 32'h0020_0008);
      bus.stall = 1'b1;
      tick(); check("stall1_pc", bus.pc, 32'h0000_3100);
      tick(); check("stall2_pc", bus.pc, 32'h0000_3100);
      bus.stall = 1'b0;
      tick(); check("jr_pc", bus.pc, 32'h0000_3200);

      // ---------------- interrupt entry at 0x3040 ----------------
      drive(PCSRC_JR, BR_EQ, 32'h0000_3040, 32'd0, 32'h0020_0008);
      tick(); check("jr2_pc", bus.pc, 32'h0000_3040);
      drive(PCSRC_SEQ, BR_EQ, 32'd0, 32'd0, 32'd0);
      bus.int_req = 1'b1;
      bus.int_en  = 1'b1;
      tick();
      check("irq_pc",  bus.pc,  32'h0000_4180);
      check("irq_epc", bus.epc, 32'h0000_3044);
      check("irq_exl", {31'd0, bus.exl},       32'h1);
      check("irq_exc_taken", {31'd0, bus.exc_taken}, 32'h1);
      // request still high but exl masks it
      tick();
      check("irq_masked_pc",  bus.pc,  32'h0000_4184);
      check("irq_masked_epc", bus.epc, 32'h0000_3044);
      check("irq_exc_pulse",  {31'd0, bus.exc_taken}, 32'h0);
      bus.int_req = 1'b0;
      drive(PCSRC_ERET, BR_EQ, 32'd0, 32'd0, 32'h4200_0018);
      tick();
      check("eret_pc",  bus.pc, 32'h0000_3044);
      check("eret_exl", {31'd0, bus.exl}, 32'h0);

      // ---------------- interrupt held off by stall, then taken ----------------
      drive(PCSRC_SEQ, BR_EQ, 32'd0, 32'd0, 32'd0);
      bus.int_req = 1'b1;
      bus.stall   = 1'b1;
      tick();
      check("irq_stall_pc",  bus.pc, 32'h0000_3044);
      check("irq_stall_exl", {31'd0, bus.exl}, 32'h0);
      bus.stall = 1'b0;
      tick();
      check("irq_late_pc",  bus.pc,  32'h0000_4180);
      check("irq_late_epc", bus.epc, 32'h0000_3048);
      bus.int_req = 1'b0;
      drive(PCSRC_ERET, BR_EQ, 32'd0, 32'd0, 32'h4200_0018);
      tick();
      check("eret2_pc", bus.pc, 32'h0000_3048);

      // ---------------- interrupt disabled ----------------
      drive(PCSRC_SEQ, BR_EQ, 32'd0, 32'd0, 32'd0);
      bus.int_req = 1'b1;
      bus.int_en  = 1'b0;
      tick();
      check("int_dis_pc",  bus.pc, 32'h0000_304C);
      check("int_dis_exl", {31'd0, bus.exl}, 32'h0);
      bus.int_req = 1'b0;
      tick(); check("pre_exc_pc", bus.pc, 32'h0000_3050);

      // ---------------- sync exception beats interrupt ----------------
      drive(PCSRC_EXC, BR_EQ, 32'd0, 32'd0, 32'd0);
      bus.int_req = 1'b1;
      bus.int_en  = 1'b1;
      tick();
      check("exc_pc",  bus.pc,  32'h0000_4180);
      check("exc_epc", bus.epc, 32'h0000_3050);
      check("exc_exl", {31'd0, bus.exl}, 32'h1);
`ifdef PC_UNIT_ALIGN_CHECK_EN
      check("exc_addr_err", {31'd0, bus.addr_err}, 32'h0);
`endif

      // ---------------- asynchronous reset inside handler ----------------
      #2 rst_n = 1'b0;
      #1;
      check("arst_pc",  bus.pc,  32'h0000_3000);
      check("arst_exl", {31'd0, bus.exl}, 32'h0);
      check("arst_epc", bus.epc, 32'h0);
      check("arst_exc_taken", {31'd0, bus.exc_taken}, 32'h0);
      bus.int_req = 1'b0;
      bus.int_en  = 1'b0;

      // ---------------- branch-condition table ----------------
      foreach (br_tab[i]) begin
         drive(PCSRC_BR, br_tab[i].cond, br_tab[i].rs, br_tab[i].rt, 32'h0);
         #1 check($sformatf("brtab%0d", i), {31'd0, bus.br_taken}, {31'd0, br_tab[i].exp});
      end
      drive(PCSRC_SEQ, BR_EQ, 32'd4, 32'd4, 32'h0);
      #1 check("br_taken_needs_src", {31'd0, bus.br_taken}, 32'h0);

      // ---------------- misaligned jr ----------------
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(PCSRC_JR, BR_EQ, 32'h0000_3002, 32'd0, 32'h0020_0008);
      tick();
`ifdef PC_UNIT_ALIGN_CHECK_EN
      check("misalign_pc",       bus.pc,  32'h0000_4180);
      check("misalign_epc",      bus.epc, 32'h0000_3000);
      check("misalign_addr_err", {31'd0, bus.addr_err},  32'h1);
      check("misalign_exc",      {31'd0, bus.exc_taken}, 32'h1);
      drive(PCSRC_SEQ, BR_EQ, 32'd0, 32'd0, 32'h0);
      tick();
      check("misalign_addr_err_pulse", {31'd0, bus.addr_err}, 32'h0);
`else
      check("misalign_pc",  bus.pc,  32'h0000_3002);
      check("misalign_exl", {31'd0, bus.exl}, 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_pc_unit
`default_nettype wire
